// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// Optional per-requester grant counters (gnt_cnt) when MEM_RR_ARBITER_STATS_EN is defined.
module mem_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         addr,
    output logic                      wr_en,
    output logic                      rd_en,
    output logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W-1:0]         rdata
`ifdef MEM_RR_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     gnt_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;

    // Latched access, sampled only in IDLE
    logic [IDX_W-1:0]    win_q, win_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   laddr_q, laddr_d;
    logic [DATA_W-1:0]   lwdata_q, lwdata_d;

    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [IDX_W-1:0]    pick;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [NUM_REQ-1:0]  win_onehot;

    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && r[IDX_W'(idx)]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        pick      = rr_pick(req, last_q);
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = (IDX_W'(i) == win_q);
        end
    end

    // Outputs are registered from the current state, so each strobe appears one cycle
    // after its state; rdata for a read therefore arrives while the FSM is in RESP.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        we_d        = we_q;
        laddr_d     = laddr_q;
        lwdata_d    = lwdata_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        busy_d      = (state_q != IDLE);
        addr_d      = '0;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        wdata_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d    = pick;
                    we_d     = sel_we;
                    laddr_d  = sel_addr;
                    lwdata_d = sel_wdata;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                gnt_d  = win_onehot;
                last_d = win_q;
                addr_d = laddr_q;
                if (we_q) begin
                    wr_en_d = 1'b1;
                    wdata_d = lwdata_q;
                    state_d = IDLE;
                end else begin
                    rd_en_d = 1'b1;
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_d = win_onehot;
                rsp_rdata_d = rdata;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            wdata_q     <= wdata_d;
        end
    end

    // Latched request fields are only consumed after IDLE loads them
    always_ff @(posedge clk) begin
        win_q    <= win_d;
        we_q     <= we_d;
        laddr_q  <= laddr_d;
        lwdata_q <= lwdata_d;
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;
    assign addr      = addr_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign wdata     = wdata_q;

`ifdef MEM_RR_ARBITER_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q[g] <= '0;
            end else if (gnt_q[g] && (cnt_q[g] != 16'hFFFF)) begin
                cnt_q[g] <= cnt_q[g] + 16'd1;
            end
        end
        assign gnt_cnt[g*16 +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed scoreboard bench for mem_rr_arbiter with a registered-read 4x8 memory model.
module tb_mem_rr_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 8;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      busy;
    logic [ADDR_W-1:0]         addr;
    logic                      wr_en;
    logic                      rd_en;
    logic [DATA_W-1:0]         wdata;
    logic [DATA_W-1:0]         rdata;
`ifdef MEM_RR_ARBITER_STATS_EN
    logic [NUM_REQ*16-1:0]     gnt_cnt;
`endif

    mem_rr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .addr      (addr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wdata     (wdata),
        .rdata     (rdata)
`ifdef MEM_RR_ARBITER_STATS_EN
        ,
        .gnt_cnt   (gnt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [4];
    always @(posedge clk) begin
        if (wr_en) mem[addr] <= wdata;
        if (rd_en) rdata <= mem[addr];
    end

    typedef struct packed {
        logic [NUM_REQ-1:0] gnt;
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
    } iss_t;

    typedef struct packed {
        logic [NUM_REQ-1:0] vld;
        logic [DATA_W-1:0]  data;
    } rsp_t;

    iss_t              iss_q[$];
    rsp_t              rsp_q[$];
    logic [DATA_W-1:0] shadow [4];
    int                exp_gcnt [NUM_REQ];
    int                errors = 0;
    int                checks = 0;
    int                cyc = 0;
    int                rd_gnt_cyc = 0;
    int                hold_left = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({gnt, rsp_valid, rsp_rdata, busy, addr, wr_en, rd_en, wdata});
    endfunction

    task automatic drive(input int i, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        req_we[i]                      = we;
        req_addr[i*ADDR_W +: ADDR_W]   = a;
        req_wdata[i*DATA_W +: DATA_W]  = d;
        req[i]                         = 1'b1;
    endtask

    task automatic expect_acc(input int i, input logic we, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input bit completes);
        iss_t e;
        rsp_t r;
        e.gnt    = '0;
        e.gnt[i] = 1'b1;
        e.we     = we;
        e.addr   = a;
        e.wdata  = d;
        iss_q.push_back(e);
        if (we) begin
            shadow[a] = d;
        end else if (completes) begin
            r.vld    = '0;
            r.vld[i] = 1'b1;
            r.data   = shadow[a];
            rsp_q.push_back(r);
        end
        exp_gcnt[i]++;
    endtask

    task automatic step();
        iss_t e;
        rsp_t r;
        @(negedge clk);
        cyc++;
        chk("wr_rd_excl", 32'(wr_en & rd_en), 0);
        chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
        chk("rsp_onehot0", 32'($onehot0(rsp_valid)), 1);
        if (!wr_en && !rd_en) chk("mem_side_idle", 32'({gnt, addr, wdata}), 0);
        if (rsp_valid == '0) chk("rsp_idle", 32'(rsp_rdata), 0);
        if (gnt != '0) begin
            if (iss_q.size() == 0) begin
                chk("unexpected_gnt", 32'(gnt), 0);
            end else begin
                e = iss_q.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("wr_en", 32'(wr_en), 32'(e.we));
                chk("rd_en", 32'(rd_en), 32'(!e.we));
                chk("addr", 32'(addr), 32'(e.addr));
                chk("wdata", 32'(wdata), e.we ? 32'(e.wdata) : 0);
                if (!e.we) rd_gnt_cyc = cyc;
            end
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) req = '0;
            end else begin
                req = req & ~gnt;
            end
        end
        if (rsp_valid != '0) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(r.vld));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(r.data));
                chk("rsp_latency", 32'(cyc - rd_gnt_cyc), 2);
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((iss_q.size() != 0 || rsp_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, 32'(iss_q.size() + rsp_q.size()) + 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) exp_gcnt[i] = 0;
        reset = 1'b1;
        #2 reset = 1'b0;

        // reset state and idle after release
        repeat (3) begin
            step();
            chk("reset_outs", all_outs(), 0);
        end
        reset = 1'b1;
        repeat (10) begin
            step();
            chk("idle_outs", all_outs(), 0);
        end

        // requester 0 writes A5 to addr 1; fields changed after sampling are ignored
        drive(0, 1'b1, 2'd1, 8'hA5);
        expect_acc(0, 1'b1, 2'd1, 8'hA5, 1'b1);
        step();
        chk("w_gnt_lat1", 32'(gnt), 0);
        req_wdata[7:0] = 8'h3C;
        req_addr[1:0]  = 2'd2;
        step();
        chk("w_gnt_lat2", 32'(gnt), 32'b01);
        chk("w_busy", 32'(busy), 1);
        step();
        chk("w_done", 32'({gnt, wr_en, busy}), 0);
        drain("w", 10);

        // requester 1 reads addr 1 back
        drive(1, 1'b0, 2'd1, 8'h00);
        expect_acc(1, 1'b0, 2'd1, 8'h00, 1'b1);
        step();
        step();
        chk("r_gnt", 32'({gnt, rd_en}), 32'b101);
        step();
        chk("r_rsp_early", 32'(rsp_valid), 0);
        step();
        chk("r_rsp", 32'({rsp_valid, rsp_rdata}), 32'({2'b10, 8'hA5}));
        drain("r", 10);

        // both requesters held, all writes: strict alternation starting at 0
        drive(0, 1'b1, 2'd0, 8'h11);
        drive(1, 1'b1, 2'd3, 8'hEE);
        hold_left = 4;
        expect_acc(0, 1'b1, 2'd0, 8'h11, 1'b1);
        expect_acc(1, 1'b1, 2'd3, 8'hEE, 1'b1);
        expect_acc(0, 1'b1, 2'd0, 8'h11, 1'b1);
        expect_acc(1, 1'b1, 2'd3, 8'hEE, 1'b1);
        drain("hold", 20);

        // concurrent reads of addr 0 and 3
        drive(0, 1'b0, 2'd0, 8'h00);
        drive(1, 1'b0, 2'd3, 8'h00);
        expect_acc(0, 1'b0, 2'd0, 8'h00, 1'b1);
        expect_acc(1, 1'b0, 2'd3, 8'h00, 1'b1);
        drain("rd2", 30);

        // reset while the read waits for memory: response is dropped
        drive(0, 1'b0, 2'd2, 8'h00);
        expect_acc(0, 1'b0, 2'd2, 8'h00, 1'b0);
        step();
        step();
        chk("abort_gnt_seen", 32'(iss_q.size()), 0);
        reset = 1'b0;
        #1;
        chk("abort_outs", all_outs(), 0);
        for (int i = 0; i < NUM_REQ; i++) exp_gcnt[i] = 0;
        step();
        chk("abort_in_reset", all_outs(), 0);
        reset = 1'b1;
        repeat (5) begin
            step();
            chk("abort_no_rsp", 32'(rsp_valid), 0);
        end

        // pointer restored by reset: requester 0 wins first again
        drive(0, 1'b0, 2'd0, 8'h00);
        drive(1, 1'b0, 2'd3, 8'h00);
        expect_acc(0, 1'b0, 2'd0, 8'h00, 1'b1);
        expect_acc(1, 1'b0, 2'd3, 8'h00, 1'b1);
        drain("post_rst", 30);

        // single active requester granted every time
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, 2'd2, 8'(8'h40 + k));
            expect_acc(1, 1'b1, 2'd2, 8'(8'h40 + k), 1'b1);
            drain("single_w", 10);
        end
        drive(1, 1'b0, 2'd2, 8'h00);
        expect_acc(1, 1'b0, 2'd2, 8'h00, 1'b1);
        drain("single_r", 10);

`ifdef MEM_RR_ARBITER_STATS_EN
        step();
        for (int i = 0; i < NUM_REQ; i++) begin
            chk("gnt_cnt", 32'(gnt_cnt[i*16 +: 16]), 32'(exp_gcnt[i]));
        end
`endif

        step();
        chk("final_idle", all_outs(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
